// File: rtl/kong_pkg.sv
// Shared Kong definitions: sprite box geometry, edge indices and the
// edge-collector FSM / hit-count types.
package kong_pkg;

    typedef logic signed [10:0] location;

    localparam location KONG_WIDTH = 11'sd64;
    localparam location KONG_HIGHT = 11'sd48;

    localparam int E_BOTTOM = 0;
    localparam int E_RIGHT  = 1;
    localparam int E_TOP    = 2;
    localparam int E_LEFT   = 3;

    localparam int EDGE_MIN_HITS = 2;
    localparam int EDGE_CNT_W    = 4;

    typedef logic [EDGE_CNT_W-1:0] hit_cnt_t;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        COLLECT    = 1'b1
    } edge_state_e;

endpackage

// File: rtl/kong_edge_counter.sv
// Saturating hit counter; a clear can load 1 so that a hit arriving with
// the frame boundary is credited to the new frame.
module kong_edge_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = inc_i ? CNT_W'(1) : '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/kong_edge_collector.sv
// Counts per-edge platform hits of the Kong sprite over a frame and reports,
// at each frame boundary, which edges touched and whether a rope overlapped.
module kong_edge_collector
    import kong_pkg::*;
#(
    parameter int MIN_HITS = EDGE_MIN_HITS,
    parameter int CNT_W    = EDGE_CNT_W
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       kongDR,
    input  location    offsetX,
    input  location    offsetY,
    input  logic       platformDR,
    input  logic       ropeDR,
    output logic [3:0] edges,
    output logic       ropeTouch,
    output logic       edgesValid
);

    localparam location     LOC_ZERO = '0;
    localparam location     X_MAX    = KONG_WIDTH - 11'sd1;
    localparam location     Y_MAX    = KONG_HIGHT - 11'sd1;
    localparam logic [31:0] MIN_U    = MIN_HITS;

    edge_state_e state_q, state_d;
    logic [3:0]  edges_q, edges_d;
    logic        rope_q, rope_d;
    logic        touch_q, touch_d;
    logic        valid_q, valid_d;

    logic                  in_box, live, hit, rope_hit;
    logic [3:0]            edge_hit;
    logic [3:0][CNT_W-1:0] cnt;

    assign in_box = (offsetX >= LOC_ZERO) && (offsetX < KONG_WIDTH) &&
                    (offsetY >= LOC_ZERO) && (offsetY < KONG_HIGHT);

    // The boundary cycle opens a new frame even out of WAIT_FRAME.
    assign live     = (state_q == COLLECT) || startOfFrame;
    assign hit      = live && kongDR && platformDR && in_box;
    assign rope_hit = live && kongDR && ropeDR && in_box;

    assign edge_hit[E_LEFT]   = hit && (offsetX == LOC_ZERO);
    assign edge_hit[E_RIGHT]  = hit && (offsetX == X_MAX);
    assign edge_hit[E_TOP]    = hit && (offsetY == LOC_ZERO);
    assign edge_hit[E_BOTTOM] = hit && (offsetY == Y_MAX);

    for (genvar e = 0; e < 4; e++) begin : g_cnt
        kong_edge_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .resetN (resetN),
            .clr_i  (startOfFrame),
            .inc_i  (edge_hit[e]),
            .cnt_o  (cnt[e])
        );
    end

    always_comb begin
        state_d = state_q;
        edges_d = edges_q;
        rope_d  = rope_q;
        touch_d = touch_q;
        valid_d = 1'b0;
        case (state_q)
            WAIT_FRAME: begin
                if (startOfFrame) begin
                    state_d = COLLECT;
                    rope_d  = rope_hit;
                end
            end
            COLLECT: begin
                if (startOfFrame) begin
                    for (int e = 0; e < 4; e++)
                        edges_d[e] = ({{(32-CNT_W){1'b0}}, cnt[e]} >= MIN_U);
                    touch_d = rope_q;
                    rope_d  = rope_hit;
                    valid_d = 1'b1;
                end else if (rope_hit) begin
                    rope_d = 1'b1;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= WAIT_FRAME;
            edges_q <= '0;
            rope_q  <= 1'b0;
            touch_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            edges_q <= edges_d;
            rope_q  <= rope_d;
            touch_q <= touch_d;
            valid_q <= valid_d;
        end
    end

    assign edges      = edges_q;
    assign ropeTouch  = touch_q;
    assign edgesValid = valid_q;

endmodule

// File: tb/tb_kong_edge_collector.sv
// Directed-vector bench for kong_edge_collector with hand-computed results.
module tb_kong_edge_collector;

    logic              clk = 1'b0;
    logic              resetN;
    logic              startOfFrame, kongDR, platformDR, ropeDR;
    logic signed [10:0] offsetX, offsetY;
    logic [3:0]        edges;
    logic              ropeTouch, edgesValid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    kong_edge_collector dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .kongDR       (kongDR),
        .offsetX      (offsetX),
        .offsetY      (offsetY),
        .platformDR   (platformDR),
        .ropeDR       (ropeDR),
        .edges        (edges),
        .ropeTouch    (ropeTouch),
        .edgesValid   (edgesValid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel cycle; inputs change on the falling edge.
    task automatic px(input logic sof, input logic k, input int x, input int y,
                      input logic p, input logic r);
        @(negedge clk);
        startOfFrame = sof;
        kongDR       = k;
        offsetX      = 11'(x);
        offsetY      = 11'(y);
        platformDR   = p;
        ropeDR       = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Close the frame with a bare SOF, then sample the cycle after it.
    task automatic close_chk(input string tag, input logic [3:0] e, input logic t);
        px(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk({tag, ".edges"}, 32'(edges), 32'(e));
        chk({tag, ".rope"},  32'(ropeTouch), 32'(t));
        chk({tag, ".valid"}, 32'(edgesValid), 32'd1);
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 0; kongDR = 0; platformDR = 0; ropeDR = 0;
        offsetX = '0; offsetY = '0;
        #12;
        chk("rst.edges", 32'(edges), 32'd0);
        chk("rst.rope",  32'(ropeTouch), 32'd0);
        chk("rst.valid", 32'(edgesValid), 32'd0);
        @(negedge clk); resetN = 1'b1;
        idle(2);

        // First SOF only opens collection; hits before it are ignored.
        px(1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
        px(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("sof1.valid", 32'(edgesValid), 32'd0);
        chk("sof1.edges", 32'(edges), 32'd0);

        for (int x = 10; x <= 12; x++) px(1'b0, 1'b1, x, 47, 1'b1, 1'b0);
        close_chk("bottom3", 4'b0001, 1'b0);
        px(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("bottom3.pulse_end", 32'(edgesValid), 32'd0);
        chk("bottom3.hold", 32'(edges), 32'd1);

        px(1'b0, 1'b1, 0, 20, 1'b1, 1'b0);
        close_chk("left1", 4'b0000, 1'b0);

        px(1'b0, 1'b1, 0, 20, 1'b1, 1'b0);
        px(1'b0, 1'b1, 0, 20, 1'b1, 1'b0);
        close_chk("left2", 4'b1000, 1'b0);

        px(1'b0, 1'b1, 63, 0, 1'b1, 1'b0);
        px(1'b0, 1'b1, 63, 0, 1'b1, 1'b0);
        close_chk("corner", 4'b0110, 1'b0);

        for (int i = 0; i < 20; i++) px(1'b0, 1'b1, 63, 10, 1'b1, 1'b0);
        close_chk("right20", 4'b0010, 1'b0);

        // Hit riding on the SOF counts toward the frame it opens.
        px(1'b1, 1'b1, 63, 5, 1'b1, 1'b0);
        px(1'b0, 1'b1, 63, 6, 1'b1, 1'b0);
        px(1'b0, 1'b1, 30, 30, 1'b0, 1'b1);
        close_chk("sofhit_rope", 4'b0010, 1'b1);

        // Out-of-box, negative and non-Kong pixels never count.
        for (int i = 0; i < 2; i++) begin
            px(1'b0, 1'b1, -1, 0, 1'b1, 1'b1);
            px(1'b0, 1'b1, 64, 0, 1'b1, 1'b0);
            px(1'b0, 1'b1, 0, 48, 1'b1, 1'b0);
            px(1'b0, 1'b1, 0, -1, 1'b1, 1'b0);
            px(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        end
        close_chk("outside", 4'b0000, 1'b0);

        for (int i = 0; i < 5; i++) px(1'b0, 1'b1, 20, 47, 1'b1, 1'b0);
        #2 resetN = 1'b0;
        #1;
        chk("midrst.edges", 32'(edges), 32'd0);
        chk("midrst.rope",  32'(ropeTouch), 32'd0);
        chk("midrst.valid", 32'(edgesValid), 32'd0);
        idle(1);
        resetN = 1'b1;
        idle(1);
        px(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("midrst.sof1.valid", 32'(edgesValid), 32'd0);
        idle(3);
        close_chk("midrst.empty", 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
